// File: rtl/barrel_pkg.sv
// Shared state encoding, raster defaults and Q3 packing for the
// barrel-correction coordinate scheduler.
package barrel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int X_HALF_DEF = 540;
    localparam int Y_HALF_DEF = 480;
    localparam int COORD_W    = 13;

    // {y, 3'b0, x, 3'b0}: signed integer coordinates as Q3 fixed point
    function automatic logic [31:0] pack_q3(
        input logic signed [COORD_W-1:0] x,
        input logic signed [COORD_W-1:0] y
    );
        return {y, 3'b000, x, 3'b000};
    endfunction

endpackage

// File: rtl/barrel_raster_ctr.sv
// Output-pixel raster counter: x sweeps left to right, y top to bottom.
// Exposes the next coordinate so the caller can register it with its handshake.
module barrel_raster_ctr
    import barrel_pkg::*;
#(
    parameter int X_HALF = X_HALF_DEF,
    parameter int Y_HALF = Y_HALF_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      reload,
    input  logic                      advance,
    output logic signed [COORD_W-1:0] x_next,
    output logic signed [COORD_W-1:0] y_next,
    output logic                      last
);

    localparam logic signed [COORD_W-1:0] X_MIN = COORD_W'(-X_HALF);
    localparam logic signed [COORD_W-1:0] X_MAX = COORD_W'(X_HALF - 1);
    localparam logic signed [COORD_W-1:0] Y_TOP = COORD_W'(Y_HALF);
    localparam logic signed [COORD_W-1:0] Y_BOT = COORD_W'(1 - Y_HALF);

    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;

    always_comb begin
        x_next = x;
        y_next = y;
        if (reload) begin
            x_next = X_MIN;
            y_next = Y_TOP;
        end else if (advance) begin
            if (x == X_MAX) begin
                x_next = X_MIN;
                y_next = y - COORD_W'(1);
            end else begin
                x_next = x + COORD_W'(1);
            end
        end
    end

    assign last = (x == X_MAX) && (y == Y_BOT);

    always_ff @(posedge clk) begin
        if (reset) begin
            x <= X_MIN;
            y <= Y_TOP;
        end else begin
            x <= x_next;
            y <= y_next;
        end
    end

endmodule

// File: rtl/barrel_coord_sched.sv
// Frame scheduler: raster issue with credit limit, stop/drain and frame accounting.
// BARREL_SCHED_CONTINUOUS_EN selects free-running frames instead of single-shot.
module barrel_coord_sched
    import barrel_pkg::*;
#(
    parameter int X_HALF          = X_HALF_DEF,
    parameter int Y_HALF          = Y_HALF_DEF,
    parameter int MAX_OUTSTANDING = 32,
    parameter int CNT_W           = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    output logic [31:0]      tIn_tdata,
    output logic             tIn_tvalid,
    input  logic             tIn_tready,
    input  logic             retire,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frame_count,
    output logic [CNT_W-1:0] outstanding,
    output logic             credit_err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    state_t                    state;
    logic                      tvalid_r;
    logic [31:0]               tdata_r;
    logic                      stop_seen;
    logic                      xfer;
    logic                      stop_any;
    logic                      reload;
    logic                      last;
    logic signed [COORD_W-1:0] x_next;
    logic signed [COORD_W-1:0] y_next;
    logic [CNT_W-1:0]          cnt_next;
    logic                      err_set;
    logic                      credit_ok;

    assign xfer       = tvalid_r & tIn_tready;
    assign stop_any   = stop | stop_seen;
    assign tIn_tvalid = tvalid_r;
    assign tIn_tdata  = tdata_r;
    assign busy       = (state != ST_IDLE);

    always_comb begin
        cnt_next = outstanding;
        err_set  = 1'b0;
        if (xfer && !retire) begin
            cnt_next = outstanding + CNT_W'(1);
        end else if (retire && !xfer) begin
            if (outstanding == '0) begin
                err_set = 1'b1;
            end else begin
                cnt_next = outstanding - CNT_W'(1);
            end
        end
    end

    // Credit gates only the raising of valid; a raised beat is never withdrawn
    assign credit_ok = (cnt_next < MAX_CNT);

    always_comb begin
        reload = 1'b0;
        if (state == ST_IDLE && start) begin
            reload = 1'b1;
        end
`ifdef BARREL_SCHED_CONTINUOUS_EN
        if (state == ST_DRAIN && outstanding == '0 && !stop_any) begin
            reload = 1'b1;
        end
`endif
    end

    barrel_raster_ctr #(
        .X_HALF (X_HALF),
        .Y_HALF (Y_HALF)
    ) u_raster (
        .clk     (clk),
        .reset   (reset),
        .reload  (reload),
        .advance (xfer),
        .x_next  (x_next),
        .y_next  (y_next),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            tvalid_r    <= 1'b0;
            tdata_r     <= '0;
            stop_seen   <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            outstanding <= '0;
            credit_err  <= 1'b0;
        end else begin
            outstanding <= cnt_next;
            frame_done  <= 1'b0;
            if (err_set) begin
                credit_err <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    stop_seen <= 1'b0;
                    if (start) begin
                        state    <= ST_RUN;
                        tvalid_r <= credit_ok;
                        tdata_r  <= pack_q3(x_next, y_next);
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        stop_seen <= 1'b1;
                    end
                    if (xfer && last) begin
                        state    <= ST_DRAIN;
                        tvalid_r <= 1'b0;
                    end else if (stop_any && (xfer || !tvalid_r)) begin
                        state    <= ST_DRAIN;
                        tvalid_r <= 1'b0;
                    end else if (xfer || !tvalid_r) begin
                        tvalid_r <= credit_ok;
                        tdata_r  <= pack_q3(x_next, y_next);
                    end
                end
                ST_DRAIN: begin
`ifdef BARREL_SCHED_CONTINUOUS_EN
                    if (stop) begin
                        stop_seen <= 1'b1;
                    end
`endif
                    if (outstanding == '0) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
`ifdef BARREL_SCHED_CONTINUOUS_EN
                        if (stop_any) begin
                            state     <= ST_IDLE;
                            stop_seen <= 1'b0;
                        end else begin
                            state    <= ST_RUN;
                            tvalid_r <= credit_ok;
                            tdata_r  <= pack_q3(x_next, y_next);
                        end
`else
                        state <= ST_IDLE;
`endif
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    tvalid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrel_coord_sched.sv
// Bench for barrel_coord_sched on a 4x4 raster with a credit limit of 4:
// pixel-index model checked every cycle plus directed literal expectations.
module tb_barrel_coord_sched;

    localparam int XH   = 2;
    localparam int YH   = 2;
    localparam int MAXO = 4;
    localparam int CW   = 3;
    localparam int NPIX = 4 * XH * YH;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          tready = 1'b0;
    logic          retire = 1'b0;
    logic [31:0]   tdata;
    logic          tvalid;
    logic          busy;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic [CW-1:0] outstanding;
    logic          credit_err;

    int n_chk = 0;
    int n_fail = 0;
    int n_done = 0;
    int beats = 0;
    bit chk_on = 1'b0;
    bit loop_en = 1'b0;
    logic [2:0] rpipe = 3'b000;
    logic [31:0] beat_data[$];

    always #5 clk = ~clk;

    barrel_coord_sched #(
        .X_HALF          (XH),
        .Y_HALF          (YH),
        .MAX_OUTSTANDING (MAXO),
        .CNT_W           (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .tIn_tdata   (tdata),
        .tIn_tvalid  (tvalid),
        .tIn_tready  (tready),
        .retire      (retire),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .outstanding (outstanding),
        .credit_err  (credit_err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pixel index p maps straight to raster coordinates
    function automatic logic [31:0] coord_word(input int p);
        int xv;
        int yv;
        logic [12:0] xs;
        logic [12:0] ys;
        xv = -XH + (p % (2 * XH));
        yv = YH - (p / (2 * XH));
        xs = 13'(xv);
        ys = 13'(yv);
        return {ys, 3'b000, xs, 3'b000};
    endfunction

    int m_mode;
    int m_pix;
    int m_fly;
    int m_frames;
    bit m_valid;
    bit m_stop;
    bit m_err;
    bit m_done;

    always @(posedge clk) begin : model
        bit x;
        bit hold;
        int fly0;
        if (reset) begin
            m_mode = 0; m_pix = 0; m_fly = 0; m_frames = 0;
            m_valid = 0; m_stop = 0; m_err = 0; m_done = 0;
        end else begin
            x = m_valid && tready;
            hold = m_valid && !x;
            fly0 = m_fly;
            if (x && !retire) m_fly++;
            else if (retire && !x) begin
                if (m_fly == 0) m_err = 1;
                else m_fly--;
            end
            m_done = 0;
            case (m_mode)
                0: begin
                    m_stop = 0;
                    if (start) begin
                        m_mode = 1;
                        m_pix = 0;
                        m_valid = (m_fly < MAXO);
                    end
                end
                1: begin
                    if (stop) m_stop = 1;
                    if (x) m_pix++;
                    if (m_pix == NPIX || (m_stop && !hold)) begin
                        m_mode = 2;
                        m_valid = 0;
                    end else if (!hold) begin
                        m_valid = (m_fly < MAXO);
                    end
                end
                default: begin
                    if (fly0 == 0) begin
                        m_done = 1;
                        m_frames = (m_frames + 1) % 65536;
                        m_mode = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("tvalid", {31'd0, tvalid}, {31'd0, m_valid});
            if (m_valid) chk("tdata", tdata, coord_word(m_pix));
            chk("busy", {31'd0, busy}, {31'd0, m_mode != 0});
            chk("frame_done", {31'd0, frame_done}, {31'd0, m_done});
            chk("frame_count", {16'd0, frame_count}, m_frames);
            chk("outstanding", {29'd0, outstanding}, m_fly);
            chk("credit_err", {31'd0, credit_err}, {31'd0, m_err});
        end
        if (frame_done) n_done++;
    end

    task automatic step();
        logic x;
        @(negedge clk);
        x = tvalid & tready;
        if (x) begin
            beats++;
            beat_data.push_back(tdata);
        end
        @(posedge clk);
        #1;
        rpipe = {rpipe[1:0], x};
        if (loop_en) retire = rpipe[2];
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && busy; i++) step();
        chk("drain_timeout_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        step();
        chk_on = 1'b1;
        step();
        chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_outstanding", {29'd0, outstanding}, 32'd0);
        chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
        reset = 1'b0;

        // full frame with retires looped back three cycles after each beat
        tready = 1'b1;
        loop_en = 1'b1;
        beats = 0;
        beat_data.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("first_tvalid", {31'd0, tvalid}, 32'd1);
        chk("first_tdata", tdata, 32'h0010_FFF0);
        wait_idle(60);
        loop_en = 1'b0;
        retire = 1'b0;
        chk("frame_beats", beats, 32'd16);
        chk("beat3", beat_data[3], 32'h0010_0008);
        chk("beat4", beat_data[4], 32'h0008_FFF0);
        chk("beat15", beat_data[15], 32'hFFF8_0008);
        chk("frame_count_1", {16'd0, frame_count}, 32'd1);
        step();
        chk("done_pulses_1", n_done, 32'd1);

        // credit exhaustion, stall, simultaneous transfer/retire, stop
        beats = 0;
        beat_data.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        chk("credit_beats", beats, 32'd4);
        chk("credit_tvalid", {31'd0, tvalid}, 32'd0);
        chk("credit_out", {29'd0, outstanding}, 32'd4);
        tready = 1'b0;
        retire = 1'b1;
        step();
        retire = 1'b0;
        chk("reraise_tvalid", {31'd0, tvalid}, 32'd1);
        chk("reraise_tdata", tdata, 32'h0008_FFF0);
        repeat (5) begin
            step();
            chk("stall_tdata", tdata, 32'h0008_FFF0);
            chk("stall_out", {29'd0, outstanding}, 32'd3);
        end
        retire = 1'b1;
        step();
        chk("out_two", {29'd0, outstanding}, 32'd2);
        tready = 1'b1;
        step();
        retire = 1'b0;
        tready = 1'b0;
        chk("both_out", {29'd0, outstanding}, 32'd2);
        chk("both_beats", beats, 32'd5);
        chk("next_tdata", tdata, 32'h0008_FFF8);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_pending_tvalid", {31'd0, tvalid}, 32'd1);
        tready = 1'b1;
        step();
        tready = 1'b0;
        chk("stop_beats", beats, 32'd6);
        chk("stop_tvalid", {31'd0, tvalid}, 32'd0);
        chk("stop_out", {29'd0, outstanding}, 32'd3);
        step();
        step();
        chk("drain_busy", {31'd0, busy}, 32'd1);
        retire = 1'b1;
        repeat (3) step();
        retire = 1'b0;
        chk("drained_busy", {31'd0, busy}, 32'd1);
        step();
        chk("stop_frame_done", {31'd0, frame_done}, 32'd1);
        chk("stop_idle", {31'd0, busy}, 32'd0);
        chk("frame_count_2", {16'd0, frame_count}, 32'd2);

        // retire with nothing in flight
        retire = 1'b1;
        step();
        retire = 1'b0;
        chk("done_pulses_2", n_done, 32'd2);
        chk("err_out", {29'd0, outstanding}, 32'd0);
        chk("err_set", {31'd0, credit_err}, 32'd1);
        repeat (3) step();
        chk("err_sticky", {31'd0, credit_err}, 32'd1);

        // reset in the middle of a frame
        tready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("pre_reset_out", {29'd0, outstanding}, 32'd3);
        tready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("mid_rst_tdata", tdata, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_out", {29'd0, outstanding}, 32'd0);
        chk("mid_rst_err", {31'd0, credit_err}, 32'd0);
        chk("mid_rst_count", {16'd0, frame_count}, 32'd0);
        retire = 1'b1;
        step();
        retire = 1'b0;
        chk("late_retire_err", {31'd0, credit_err}, 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_tvalid", {31'd0, tvalid}, 32'd1);
        chk("restart_tdata", tdata, 32'h0010_FFF0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
